// File: rtl/smpc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : smpc_pkg
//  Description : Shared types and constants for the Saturn digital-pad scanner
//  Revision    : 1.0  initial release
// ============================================================================
package smpc_pkg;

    // Scan sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        NEXT   = 2'd2,
        COMMIT = 2'd3
    } scan_state_t;

    // {TH,TR} select value for each of the four pad phases
    localparam logic [1:0] PH_SEL [4] = '{2'b00, 2'b01, 2'b10, 2'b11};

    // ID bits returned in phase 3 by a standard digital pad
    localparam logic [2:0]  PAD_ID_STD = 3'b100;

    // Button word reported when no standard pad is present
    localparam logic [15:0] PAD_NONE   = 16'hFFFF;

    // TH and TR are outputs, TL and D3..D0 are inputs
    localparam logic [6:0]  PORT_OE    = 7'b1100000;

    // Port drive while not being scanned: {TH,TR}=11, data bits low
    localparam logic [6:0]  PORT_IDLE  = 7'b1100000;

    // True when the phase-3 nibble identifies a standard pad
    function automatic logic pad_conn(input logic [3:0] ph3);
        return (ph3[2:0] == PAD_ID_STD);
    endfunction

    // Pack the four phase nibbles into the active-low button word
    function automatic logic [15:0] pad_word(input logic [3:0] ph0,
                                             input logic [3:0] ph1,
                                             input logic [3:0] ph2,
                                             input logic [3:0] ph3);
        if (pad_conn(ph3)) begin
            return {ph2, ph1, ph0, ph3[3], 3'b111};
        end
        return PAD_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/smpc_port_sync.sv
`default_nettype none
// ============================================================================
//  Module      : smpc_port_sync
//  Description : Two-flop synchroniser for one controller port's input pins
//  Revision    : 1.0  initial release
// ============================================================================
module smpc_port_sync #(
    parameter int WIDTH = 7
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Free-running double flop; pins idle high, so reset to all ones
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/smpc_pad_scan.sv
`default_nettype none
// ============================================================================
//  Module      : smpc_pad_scan
//  Description : Scans both Saturn pad ports through four TH/TR phases and
//                publishes packed active-low button words plus connect flags
//  Revision    : 1.0  initial release
// ============================================================================
module smpc_pad_scan #(
    parameter int SETTLE_CYCLES = 16
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CE,
    input  logic        START,
    output logic        BUSY,
    output logic        DONE,
    input  logic [6:0]  P1I,
    input  logic [6:0]  P2I,
    output logic [6:0]  P1O,
    output logic [6:0]  P2O,
    output logic [6:0]  P1OE,
    output logic [6:0]  P2OE,
    output logic [15:0] PAD1,
    output logic [15:0] PAD2,
    output logic        PAD1_CONN,
    output logic        PAD2_CONN
);
    import smpc_pkg::*;

    localparam logic [7:0] c_cnt_reload = 8'(SETTLE_CYCLES - 1);

    logic [6:0]  w_p1_sync;
    logic [6:0]  w_p2_sync;
    logic        w_sync_unused;

    scan_state_t r_state;
    scan_state_t w_state_nxt;
    logic [7:0]  r_cnt;
    logic        r_port;            // 0 = port 1, 1 = port 2
    logic [1:0]  r_phase;
    logic        w_port_nxt;
    logic [1:0]  w_phase_nxt;
    logic [1:0][3:0][3:0] r_shadow; // [port][phase] nibbles
    logic [6:0]  r_p1o;
    logic [6:0]  r_p2o;
    logic [6:0]  w_p1o_nxt;
    logic [6:0]  w_p2o_nxt;
    logic [15:0] r_pad1;
    logic [15:0] r_pad2;
    logic        r_conn1;
    logic        r_conn2;
    logic        r_busy;
    logic        r_done;

    smpc_port_sync #(.WIDTH(7)) u_sync_p1 (
        .CLK   (CLK),
        .RST_N (RST_N),
        .i_d   (P1I),
        .o_q   (w_p1_sync)
    );

    smpc_port_sync #(.WIDTH(7)) u_sync_p2 (
        .CLK   (CLK),
        .RST_N (RST_N),
        .i_d   (P2I),
        .o_q   (w_p2_sync)
    );

    // TH/TR/TL echoes are synchronised but the standard-pad protocol ignores them
    assign w_sync_unused = ^{w_p1_sync[6:4], w_p2_sync[6:4]};

    // Next state, next port/phase and the select lines for the coming tick
    always_comb begin
        w_state_nxt = r_state;
        w_port_nxt  = r_port;
        w_phase_nxt = r_phase;
        w_p1o_nxt   = PORT_IDLE;
        w_p2o_nxt   = PORT_IDLE;
        case (r_state)
            IDLE: begin
                if (START) begin
                    w_state_nxt = SETTLE;
                    w_port_nxt  = 1'b0;
                    w_phase_nxt = 2'd0;
                end
            end
            SETTLE: begin
                if (r_cnt == 8'd0) begin
                    w_state_nxt = NEXT;
                end
            end
            NEXT: begin
                if (r_port && (r_phase == 2'd3)) begin
                    w_state_nxt = COMMIT;
                end else begin
                    w_state_nxt = SETTLE;
                    {w_port_nxt, w_phase_nxt} = {r_port, r_phase} + 3'd1;
                end
            end
            COMMIT: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        // The select is held through NEXT so the pad sees a stable phase
        if ((w_state_nxt == SETTLE) || (w_state_nxt == NEXT)) begin
            if (w_port_nxt) begin
                w_p2o_nxt = {PH_SEL[w_phase_nxt], 5'b00000};
            end else begin
                w_p1o_nxt = {PH_SEL[w_phase_nxt], 5'b00000};
            end
        end
    end

    // Sequencer registers, settle counter, shadow capture and output commit
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state  <= IDLE;
            r_cnt    <= 8'd0;
            r_port   <= 1'b0;
            r_phase  <= 2'd0;
            r_shadow <= '1;
            r_p1o    <= PORT_IDLE;
            r_p2o    <= PORT_IDLE;
            r_pad1   <= PAD_NONE;
            r_pad2   <= PAD_NONE;
            r_conn1  <= 1'b0;
            r_conn2  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else if (CE) begin
            r_state <= w_state_nxt;
            r_port  <= w_port_nxt;
            r_phase <= w_phase_nxt;
            r_p1o   <= w_p1o_nxt;
            r_p2o   <= w_p2o_nxt;
            r_done  <= (r_state == COMMIT);
            case (r_state)
                IDLE: begin
                    if (START) begin
                        r_busy <= 1'b1;
                        r_cnt  <= c_cnt_reload;
                    end
                end
                SETTLE: begin
                    if (r_cnt == 8'd0) begin
                        r_shadow[r_port][r_phase] <= r_port ? w_p2_sync[3:0]
                                                            : w_p1_sync[3:0];
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                NEXT: begin
                    r_cnt <= c_cnt_reload;
                end
                COMMIT: begin
                    r_busy  <= 1'b0;
                    r_pad1  <= pad_word(r_shadow[0][0], r_shadow[0][1],
                                        r_shadow[0][2], r_shadow[0][3]);
                    r_pad2  <= pad_word(r_shadow[1][0], r_shadow[1][1],
                                        r_shadow[1][2], r_shadow[1][3]);
                    r_conn1 <= pad_conn(r_shadow[0][3]);
                    r_conn2 <= pad_conn(r_shadow[1][3]);
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign BUSY      = r_busy;
    assign DONE      = r_done;
    assign P1O       = r_p1o;
    assign P2O       = r_p2o;
    assign P1OE      = PORT_OE;
    assign P2OE      = PORT_OE;
    assign PAD1      = r_pad1;
    assign PAD2      = r_pad2;
    assign PAD1_CONN = r_conn1;
    assign PAD2_CONN = r_conn2;

endmodule
`default_nettype wire

// File: tb/tb_smpc_pad_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_smpc_pad_scan
//  Description : Scoreboard bench for the Saturn pad scanner with a
//                behavioural pad model on each port
//  Revision    : 1.0  initial release
// ============================================================================
module tb_smpc_pad_scan;

    localparam int SETTLE  = 16;
    localparam int LATENCY = 138;   // 1 + 8*(16+1) + 1

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        CE;
    logic        START;
    logic        BUSY, DONE;
    logic [6:0]  P1I, P2I, P1O, P2O, P1OE, P2OE;
    logic [15:0] PAD1, PAD2;
    logic        PAD1_CONN, PAD2_CONN;

    smpc_pad_scan #(.SETTLE_CYCLES(SETTLE)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .CE        (CE),
        .START     (START),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .P1I       (P1I),
        .P2I       (P2I),
        .P1O       (P1O),
        .P2O       (P2O),
        .P1OE      (P1OE),
        .P2OE      (P2OE),
        .PAD1      (PAD1),
        .PAD2      (PAD2),
        .PAD1_CONN (PAD1_CONN),
        .PAD2_CONN (PAD2_CONN)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [15:0] pad1;
        logic [15:0] pad2;
        logic        c1;
        logic        c2;
    } exp_t;

    exp_t       sb[$];
    logic [1:0] p1_seq[$];
    logic [1:0] p2_seq[$];
    int         n_checks = 0;
    int         n_err    = 0;
    int         done_cnt = 0;
    int         ce_tick  = 0;
    int         ce_div   = 1;
    logic [3:0] pad1_nib [4];
    logic [3:0] pad2_nib [4];

    // Pad model: the nibble returned follows the {TH,TR} the scanner drives
    always_comb begin
        P1I = {P1O[6:5], 1'b1, pad1_nib[P1O[6:5]]};
        P2I = {P2O[6:5], 1'b1, pad2_nib[P2O[6:5]]};
    end

    // Clock-enable generator: one enabled tick in every ce_div clocks
    initial begin
        int ph;
        ph = 0;
        CE = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            ph = (ph + 1 >= ce_div) ? 0 : ph + 1;
            CE = (ph == 0);
        end
    end

    always @(posedge CLK) begin
        if (CE) ce_tick <= ce_tick + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // v = {ph3, ph2, ph1, ph0} nibbles
    task automatic load_pads(input logic [15:0] v1, input logic [15:0] v2);
        for (int i = 0; i < 4; i++) begin
            pad1_nib[i] = v1[4*i +: 4];
            pad2_nib[i] = v2[4*i +: 4];
        end
    endtask

    task automatic push_exp(input logic [15:0] p1, input logic [15:0] p2,
                            input logic c1, input logic c2);
        exp_t e;
        e.pad1 = p1;
        e.pad2 = p2;
        e.c1   = c1;
        e.c2   = c2;
        sb.push_back(e);
    endtask

    task automatic issue_start();
        START = 1'b1;
        do @(posedge CLK); while (!CE);
        #2 START = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int k;
        k = 0;
        while (done_cnt < target && k < 5000) begin
            @(negedge CLK);
            #1;
            k++;
        end
        chk("done_arrived", 32'(done_cnt >= target), 32'd1);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_busy",  32'(BUSY),      32'd0);
        chk("rst_done",  32'(DONE),      32'd0);
        chk("rst_pad1",  32'(PAD1),      32'hFFFF);
        chk("rst_pad2",  32'(PAD2),      32'hFFFF);
        chk("rst_conn1", 32'(PAD1_CONN), 32'd0);
        chk("rst_conn2", 32'(PAD2_CONN), 32'd0);
        chk("rst_p1o",   32'(P1O),       32'h60);
        chk("rst_p2o",   32'(P2O),       32'h60);
        chk("rst_p1oe",  32'(P1OE),      32'h60);
        chk("rst_p2oe",  32'(P2OE),      32'h60);
    endtask

    // Monitor: compares each DONE against the scoreboard and logs selects
    initial begin
        logic done_q, busy_q;
        logic [1:0] p1_last, p2_last;
        int start_tick, done_tick;
        exp_t e;
        done_q = 1'b0; busy_q = 1'b0;
        p1_last = 2'b11; p2_last = 2'b11;
        start_tick = 0; done_tick = 0;
        forever begin
            @(negedge CLK);
            if (BUSY && !busy_q) start_tick = ce_tick;
            if (DONE && !done_q) begin
                done_cnt++;
                done_tick = ce_tick;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_done: actual=1 required=0");
                end else begin
                    e = sb.pop_front();
                    chk("pad1",      32'(PAD1),      32'(e.pad1));
                    chk("pad2",      32'(PAD2),      32'(e.pad2));
                    chk("pad1_conn", 32'(PAD1_CONN), 32'(e.c1));
                    chk("pad2_conn", 32'(PAD2_CONN), 32'(e.c2));
                    chk("latency",   32'(ce_tick - start_tick + 1), 32'(LATENCY));
                    chk("busy_at_done", 32'(BUSY), 32'd0);
                    chk("p1o_low",   32'(P1O[4:0]), 32'd0);
                end
            end
            if (!DONE && done_q && RST_N) chk("done_width", 32'(ce_tick - done_tick), 32'd1);
            if (P1O[6:5] != p1_last) begin p1_seq.push_back(P1O[6:5]); p1_last = P1O[6:5]; end
            if (P2O[6:5] != p2_last) begin p2_seq.push_back(P2O[6:5]); p2_last = P2O[6:5]; end
            busy_q = BUSY;
            done_q = DONE;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0;
        RST_N = 1'b0;
        START = 1'b0;
        load_pads(16'hCFFF, 16'hCFFF);
        repeat (2) @(negedge CLK);
        chk_reset_outputs();
        @(posedge CLK); #2 RST_N = 1'b1;
        repeat (3) @(posedge CLK); #2;

        // Both pads idle
        push_exp(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
        issue_start(); wait_done(1);

        // Port 1: A and Up pressed
        load_pads(16'hCEBF, 16'hCFFF);
        push_exp(16'hEBFF, 16'hFFFF, 1'b1, 1'b1);
        issue_start(); wait_done(2);

        // Port 1: R and L pressed; port 2 not a standard pad
        load_pads(16'h4FF7, 16'hFFFF);
        push_exp(16'hFF77, 16'hFFFF, 1'b1, 1'b0);
        issue_start(); wait_done(3);

        // START held high across a scan: ignored while busy, taken right after DONE
        load_pads(16'hCFFF, 16'hCFFE);
        push_exp(16'hFFFF, 16'hFFEF, 1'b1, 1'b1);
        push_exp(16'hFFFF, 16'hFFEF, 1'b1, 1'b1);
        d0 = done_cnt;
        START = 1'b1;
        wait_done(d0 + 1);
        chk("one_done_while_busy", 32'(done_cnt), 32'(d0 + 1));
        @(posedge CLK); #2 START = 1'b0;
        chk("restart_busy", 32'(BUSY), 32'd1);
        wait_done(d0 + 2);
        repeat (400) @(negedge CLK);
        chk("no_extra_done", 32'(done_cnt), 32'(d0 + 2));

        // CE 1-of-3 with a phase-sequence log
        ce_div = 3;
        repeat (6) @(posedge CLK); #2;
        p1_seq.delete(); p2_seq.delete();
        load_pads(16'hC7FF, 16'hCF7F);
        push_exp(16'h7FFF, 16'hF7FF, 1'b1, 1'b1);
        d0 = done_cnt;
        issue_start(); wait_done(d0 + 1);
        chk("p1_seq_len", 32'(p1_seq.size()), 32'd4);
        chk("p2_seq_len", 32'(p2_seq.size()), 32'd4);
        for (int i = 0; i < 4 && i < p1_seq.size(); i++) chk("p1_seq", 32'(p1_seq[i]), 32'(i));
        for (int i = 0; i < 4 && i < p2_seq.size(); i++) chk("p2_seq", 32'(p2_seq[i]), 32'(i));
        ce_div = 1;
        repeat (6) @(posedge CLK); #2;

        // Reset in the middle of a scan, then a normal scan
        load_pads(16'hCFFF, 16'hCFFF);
        push_exp(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
        d0 = done_cnt;
        issue_start();
        repeat (59) @(posedge CLK);
        #3 RST_N = 1'b0;
        #1 chk_reset_outputs();
        void'(sb.pop_back());
        repeat (3) @(posedge CLK);
        #3 RST_N = 1'b1;
        repeat (3) @(posedge CLK); #2;
        chk("no_done_after_reset", 32'(done_cnt), 32'(d0));
        load_pads(16'hCEBF, 16'hCFFF);
        push_exp(16'hEBFF, 16'hFFFF, 1'b1, 1'b1);
        issue_start(); wait_done(d0 + 1);

        repeat (5) @(negedge CLK);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/smpc_pad_scan.md
# smpc_pad_scan

Saturn digital-pad scanner that sits directly upstream of the SMPC peripheral path. On a start request it drives the TH/TR select lines of both controller ports through four phases, samples the 4-bit nibbles returned, and presents one packed 16-bit active-low button word per port, with a connected flag. The SMPC INTBACK peripheral stage consumes these words as its JOY inputs.

## Interface
- SETTLE_CYCLES, 16: CE ticks per select phase, including synchroniser delay; legal range 3..255.
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous, active-low reset.
- CE  in  1  clock enable; all state except the input synchroniser advances only when CE=1.
- START  in  1  scan request; accepted only in IDLE on a CE tick.
- BUSY  out  1  high from acceptance until DONE.
- DONE  out  1  one-CE-tick pulse when PAD1/PAD2 update.
- P1I / P2I  in  7  port input pins {TH,TR,TL,D3..D0}; asynchronous.
- P1O / P2O  out  7  port output values.
- P1OE / P2OE  out  7  per-bit output enables, 1 = drive.
- PAD1 / PAD2  out  16  packed buttons, active-low.
- PAD1_CONN / PAD2_CONN  out  1  standard pad detected.

## Operation
- Each P?I is double-flopped on CLK with no CE gating. Only the synchronised value is sampled.
- P?OE is constant 7'b1100000: TH and TR are driven, and the other bits are inputs. P?O[4:0] is always 0.
- Phase encoding on {TH,TR}:
  - ph0 = 00, returns {R,X,Y,Z}
  - ph1 = 01, returns {St,A,C,B}
  - ph2 = 10, returns {Rt,Lt,Dn,Up}
  - ph3 = 11, returns {L,ID2,ID1,ID0}
- In IDLE, both ports drive {TH,TR}=11.
- States:
  - IDLE: on START with CE, set BUSY and go to SETTLE with port=1, phase=0, cnt=SETTLE_CYCLES-1.
  - SETTLE: the current port drives the phase select, and the non-scanned port stays at 11. Decrement cnt each CE tick. When cnt==0, latch D3..D0 into shadow[port][phase] and go to NEXT.
  - NEXT: step to the next phase, or after ph3 to port 2 ph0. Reload cnt and return to SETTLE. After port 2 ph3, go to COMMIT.
  - COMMIT: update both PAD words and both CONN flags in the same tick. Pulse DONE, clear BUSY, and go to IDLE.
- Packing: PAD = {ph2, ph1, ph0, ph3[3], 3'b111}.
- Connected means ph3[2:0]==3'b100. If a port is not connected, PAD=16'hFFFF and CONN=0.
- PAD and CONN hold their values between scans. No output changes mid-scan.

## Timing
- Reset values:
  - P?O = 7'b1100000, P?OE = 7'b1100000
  - PAD? = 16'hFFFF, PAD?_CONN = 0
  - BUSY = 0, DONE = 0
  - state = IDLE, cnt = 0
- Latency, counted in CE ticks from START acceptance to DONE: 1 + 8×(SETTLE_CYCLES+1) + 1. With the default, this is 138.
- The select change becomes visible on P?O in the tick it enters SETTLE. The sample is taken SETTLE_CYCLES CE ticks later.
- START is ignored while BUSY, including in the COMMIT tick. START in the tick after DONE is accepted.
- CE=0 freezes the FSM, cnt, P?O and DONE. A DONE pulse lasts exactly one CE tick.
- RST_N asserted mid-scan returns all outputs to reset values immediately. The partial shadow is discarded.
- A pad that changes between phases yields a mixed-phase word. This is acceptable; there is no retry.

## Structure
- Package smpc_pkg holds:
  - the scan state enum (IDLE, SETTLE, NEXT, COMMIT)
  - phase select constants PH_SEL[4]
  - PAD_ID_STD = 3'b100
  - PAD_NONE = 16'hFFFF
- Sub-module smpc_port_sync: 7-bit two-flop synchroniser, instantiated once per port.
- FSM, counter, shadow nibbles (2×4×4 bits) and packing live in smpc_pad_scan.

## Test plan
- Both pads idle (all D=1, ID=100), START → DONE at tick 138; PAD1=PAD2=16'hFFFF; CONN=1/1.
- Port 1 with A and Up pressed (ph1=4'b1011, ph2=4'b1110), port 2 idle → PAD1=16'hEBFF, PAD2=16'hFFFF.
- Port 2 ph3 returns 4'b1111 → PAD2_CONN=0, PAD2=16'hFFFF; port 1 unaffected.
- START repeated while BUSY → ignored; exactly one DONE; the next START one tick after DONE gives a second scan.
- CE toggling 1-of-3 → same results; DONE arrives after 138 CE ticks; P?O phase sequence is 00,01,10,11 per port.
- RST_N pulsed at tick 60 → outputs return to reset values; a subsequent full scan completes normally.
